// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and its datapath.
// master = controller (drives control lines), slave = datapath (drives opcode).
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       PCWrite;
  logic       BranchEq;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic       ZeroExt;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    input  opcode,
    output PCWrite, BranchEq, BranchNe, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, ALUSrcA, RegWrite, RegDst, ZeroExt, ALUOp, ALUSrcB,
           PCSource, state, illegal_op
  );

  modport slave (
    output opcode,
    input  PCWrite, BranchEq, BranchNe, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, ALUSrcA, RegWrite, RegDst, ZeroExt, ALUOp, ALUSrcB,
           PCSource, state, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a multicycle MIPS-style datapath (lw/sw/R/beq/bne/j/addi/andi).
module multicycle_control (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    REX     = 4'd6,
    RWB     = 4'd7,
    BEQ     = 4'd8,
    BNE     = 4'd9,
    JUMP    = 4'd10,
    ADDI_EX = 4'd11,
    ANDI_EX = 4'd12,
    IMMWB   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  state_t st;
  logic   legal;

  // Opcode legality, only consulted in DECODE
  always_comb begin
    legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // State register and next-state sequencing; codes 14/15 fall to FETCH via default
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
    end else begin
      case (st)
        FETCH:   st <= DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_RTYPE:      st <= REX;
            OP_LW, OP_SW:  st <= MEMADR;
            OP_BEQ:        st <= BEQ;
            OP_BNE:        st <= BNE;
            OP_J:          st <= JUMP;
            OP_ADDI:       st <= ADDI_EX;
            OP_ANDI:       st <= ANDI_EX;
            default:       st <= FETCH;
          endcase
        end
        MEMADR:  st <= (bus.opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   st <= MEMWB;
        REX:     st <= RWB;
        ADDI_EX: st <= IMMWB;
        ANDI_EX: st <= IMMWB;
        default: st <= FETCH;
      endcase
    end
  end

  assign bus.state = st;

  // Control decode from the registered state; reset gates everything off
  // combinationally so no write enable survives the cycle reset rises.
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.BranchEq   = 1'b0;
    bus.BranchNe   = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.RegDst     = 1'b0;
    bus.ZeroExt    = 1'b0;
    bus.ALUOp      = '0;
    bus.ALUSrcB    = '0;
    bus.PCSource   = '0;
    bus.illegal_op = 1'b0;
    if (!reset) begin
      case (st)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.IRWrite = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.PCWrite = 1'b1;
        end
        DECODE: begin
          bus.ALUSrcB    = 2'b11;
          bus.illegal_op = ~legal;
        end
        MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        MEMRD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        MEMWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        MEMWR: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        REX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = 2'b10;
        end
        RWB: begin
          bus.RegDst   = 1'b1;
          bus.RegWrite = 1'b1;
        end
        BEQ: begin
          bus.ALUSrcA  = 1'b1;
          bus.ALUOp    = 2'b01;
          bus.PCSource = 2'b01;
          bus.BranchEq = 1'b1;
        end
        BNE: begin
          bus.ALUSrcA  = 1'b1;
          bus.ALUOp    = 2'b01;
          bus.PCSource = 2'b01;
          bus.BranchNe = 1'b1;
        end
        JUMP: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b10;
        end
        ADDI_EX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        ANDI_EX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          bus.ALUOp   = 2'b11;
          bus.ZeroExt = 1'b1;
        end
        IMMWB: begin
          bus.RegWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expected
// control vectors, a negedge monitor pops and compares them.
module tb_multicycle_control;

  logic clk;
  logic reset;
  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // {illegal_op, 18 control bits, state[3:0]}
  logic [22:0] sb [$];

  // Hand-written control rows, order:
  // PCWrite BranchEq BranchNe IorD MemRead MemWrite MemtoReg IRWrite
  // ALUSrcA RegWrite RegDst ZeroExt | ALUOp | ALUSrcB | PCSource
  function automatic logic [17:0] ctrl_of(input int s);
    case (s)
      0:  return 18'b100010010000_00_01_00;
      1:  return 18'b000000000000_00_11_00;
      2:  return 18'b000000001000_00_10_00;
      3:  return 18'b000110000000_00_00_00;
      4:  return 18'b000000100100_00_00_00;
      5:  return 18'b000101000000_00_00_00;
      6:  return 18'b000000001000_10_00_00;
      7:  return 18'b000000000110_00_00_00;
      8:  return 18'b010000001000_01_00_01;
      9:  return 18'b001000001000_01_00_01;
      10: return 18'b100000000000_00_00_10;
      11: return 18'b000000001000_00_10_00;
      12: return 18'b000000001001_11_10_00;
      13: return 18'b000000000100_00_00_00;
      default: return 18'b0;
    endcase
  endfunction

  function automatic logic [22:0] actual_vec();
    return {bus.illegal_op, bus.PCWrite, bus.BranchEq, bus.BranchNe, bus.IorD,
            bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.ALUSrcA,
            bus.RegWrite, bus.RegDst, bus.ZeroExt, bus.ALUOp, bus.ALUSrcB,
            bus.PCSource, bus.state};
  endfunction

  // Monitor: compares one expected vector per cycle, mid-cycle
  int mon_idx = 0;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [22:0] e, a;
      e = sb.pop_front();
      a = actual_vec();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cyc%0d: got %b want %b", mon_idx, a, e);
      end
      mon_idx++;
    end
  end

  // One cycle with expectation e, then advance to just after the next edge
  task automatic step(input logic [22:0] e);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Run one instruction: each listed state is one cycle; illegal flagged in DECODE
  task automatic run(input logic [5:0] op, input int states[$], input bit ill);
    bus.opcode = op;
    foreach (states[i]) begin
      logic [3:0] s4;
      s4 = 4'(states[i]);
      step({(ill && states[i] == 1), ctrl_of(states[i]), s4});
    end
  endtask

  logic [5:0] ops [4];
  int fetches;
  int elapsed;

  initial begin
    reset = 1'b1;
    bus.opcode = 6'b000000;
    @(posedge clk);
    #1;
    // reset held: all outputs 0, state 0
    repeat (3) step(23'b0);
    reset = 1'b0;

    run(6'b100011, '{0, 1, 2, 3, 4}, 1'b0);   // lw
    run(6'b000000, '{0, 1, 6, 7}, 1'b0);      // R-type
    run(6'b001100, '{0, 1, 12, 13}, 1'b0);    // andi
    run(6'b000101, '{0, 1, 9}, 1'b0);         // bne
    run(6'b111111, '{0, 1}, 1'b1);            // illegal
    run(6'b101011, '{0, 1, 2, 5}, 1'b0);      // sw
    run(6'b000100, '{0, 1, 8}, 1'b0);         // beq
    run(6'b000010, '{0, 1, 10}, 1'b0);        // j
    run(6'b001000, '{0, 1, 11, 13}, 1'b0);    // addi

    // reset rising during MEMWR: MemWrite drops immediately, state still 5
    run(6'b101011, '{0, 1, 2}, 1'b0);
    reset = 1'b1;
    step({1'b0, 18'b0, 4'd5});
    step(23'b0);
    reset = 1'b0;
    run(6'b101011, '{0, 1, 2, 5}, 1'b0);

    // Back-to-back sw, beq, j, addi timed by observing FETCH entries
    ops[0] = 6'b101011;
    ops[1] = 6'b000100;
    ops[2] = 6'b000010;
    ops[3] = 6'b001000;
    fetches = 0;
    elapsed = -1;
    for (int c = 0; c < 40 && fetches < 5; c++) begin
      if (bus.state == 4'd0) begin
        fetches++;
        if (fetches < 5) bus.opcode = ops[fetches-1];
        else elapsed = c;
      end
      if (fetches < 5) begin
        @(posedge clk);
        #1;
      end
    end
    total++;
    if (elapsed != 14) begin
      bad++;
      $display("FAIL b2b_latency: got %0d want 14", elapsed);
    end

    @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
